// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter for fetch, load/store and debug requesters.
// Combinational grant with registered response steering and fetch anti-starvation.
module sram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_AW     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              oob_err,
    output logic [31:0]       if_stall_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IF,
        SEL_DM,
        SEL_DBG
    } sel_e;

    sel_e              resp_sel_q, resp_sel_d;
    logic              resp_oob_q, resp_oob_d;
    logic              oob_err_q, oob_err_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [31:0]       if_stall_q, if_stall_d;

    logic              if_force;
    logic              gnt_if, gnt_dm, gnt_dbg, any_gnt;
    logic              win_we, win_in_range;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [3:0]        win_be;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        if (v >= SW'(STARVE_MAX)) begin
            return SW'(STARVE_MAX);
        end
        return v + 1'b1;
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (a >> (RAM_AW + 2)) == '0;
    endfunction

    // Grant selection and winner mux; everything is held at zero during reset.
    always_comb begin
        if_force = if_req && (starve_q == SW'(STARVE_MAX));
        gnt_dbg  = !rst && dbg_req;
        gnt_if   = !rst && !dbg_req && if_req && (!dm_req || if_force);
        gnt_dm   = !rst && !dbg_req && dm_req && !if_force;
        any_gnt  = gnt_dbg || gnt_dm || gnt_if;

        win_addr  = '0;
        win_wdata = '0;
        win_be    = 4'h0;
        win_we    = 1'b0;
        if (gnt_dbg) begin
            win_addr  = dbg_addr;
            win_wdata = dbg_wdata;
            win_be    = 4'hF;
            win_we    = dbg_we;
        end else if (gnt_dm) begin
            win_addr  = dm_addr;
            win_wdata = dm_wdata;
            win_be    = dm_be;
            win_we    = dm_we;
        end else if (gnt_if) begin
            win_addr  = if_addr;
        end
        win_in_range = addr_in_range(win_addr);
    end

    assign if_gnt    = gnt_if;
    assign dm_gnt    = gnt_dm;
    assign dbg_gnt   = gnt_dbg;

    assign ram_en    = any_gnt && win_in_range;
    assign ram_we    = (ram_en && win_we) ? win_be : 4'h0;
    assign ram_addr  = win_addr[RAM_AW+1:2];
    assign ram_wdata = win_wdata;

    // Next-state: response steering, starvation tracking, stall counting.
    always_comb begin
        resp_sel_d = SEL_NONE;
        resp_oob_d = 1'b0;
        oob_err_d  = any_gnt && !win_in_range;
        starve_d   = starve_q;
        if_stall_d = if_stall_q;

        if (any_gnt && !win_we) begin
            resp_oob_d = !win_in_range;
            if (gnt_dbg) begin
                resp_sel_d = SEL_DBG;
            end else if (gnt_dm) begin
                resp_sel_d = SEL_DM;
            end else begin
                resp_sel_d = SEL_IF;
            end
        end

        // Debug traffic neither advances nor clears the fetch's wait count.
        if (!if_req || gnt_if) begin
            starve_d = '0;
        end else if (!gnt_dbg) begin
            starve_d = sat_inc(starve_q);
        end

        if (if_req && !gnt_if) begin
            if_stall_d = if_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sel_q <= SEL_NONE;
            resp_oob_q <= 1'b0;
            oob_err_q  <= 1'b0;
            starve_q   <= '0;
            if_stall_q <= '0;
        end else begin
            resp_sel_q <= resp_sel_d;
            resp_oob_q <= resp_oob_d;
            oob_err_q  <= oob_err_d;
            starve_q   <= starve_d;
            if_stall_q <= if_stall_d;
        end
    end

    // Response stage: a read granted just before reset must not surface.
    assign if_rvalid  = !rst && (resp_sel_q == SEL_IF);
    assign dm_rvalid  = !rst && (resp_sel_q == SEL_DM);
    assign dbg_rvalid = !rst && (resp_sel_q == SEL_DBG);

    assign if_rdata   = (if_rvalid  && !resp_oob_q) ? ram_rdata : '0;
    assign dm_rdata   = (dm_rvalid  && !resp_oob_q) ? ram_rdata : '0;
    assign dbg_rdata  = (dbg_rvalid && !resp_oob_q) ? ram_rdata : '0;

    assign oob_err      = oob_err_q;
    assign if_stall_cnt = if_stall_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized and directed bench for sram_arbiter against a transaction-level model
// holding a reference memory image and per-requester expectations.
module tb_sram_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int RAM_AW     = 14;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, dm_req, dm_we, dbg_req, dbg_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] if_addr, dm_addr, dbg_addr;
    logic [DATA_W-1:0] dm_wdata, dbg_wdata;
    logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] if_rdata, dm_rdata, dbg_rdata;
    logic              ram_en, oob_err;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [31:0]       if_stall_cnt;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .oob_err(oob_err), .if_stall_cnt(if_stall_cnt)
    );

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // The physical SRAM, driven only by the DUT's ram_* pins (read-first).
    logic [DATA_W-1:0] sram [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata      <= sram[ram_addr];
            sram[ram_addr] <= (sram[ram_addr] & ~be_mask(ram_we)) | (ram_wdata & be_mask(ram_we));
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [0:(1<<RAM_AW)-1];
    int                starve;
    logic [31:0]       stall;
    int                resp_who;   // 0 none, 1 fetch, 2 data, 3 debug
    logic [31:0]       resp_data;
    logic              oob_pend;
    int                last_who;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_check();
        int                who;
        logic [ADDR_W-1:0] a;
        logic              inr, we, en;
        logic [3:0]        be;
        logic [DATA_W-1:0] wd;
        logic [RAM_AW-1:0] w;

        who = 0;
        if (dbg_req)                                              who = 3;
        else if (if_req && (!dm_req || starve == STARVE_MAX))     who = 1;
        else if (dm_req)                                          who = 2;

        a = '0; we = 1'b0; be = 4'h0; wd = '0;
        case (who)
            3: begin a = dbg_addr; we = dbg_we; be = 4'hF;  wd = dbg_wdata; end
            2: begin a = dm_addr;  we = dm_we;  be = dm_be; wd = dm_wdata;  end
            1: begin a = if_addr; end
            default: ;
        endcase
        inr = (a[ADDR_W-1:RAM_AW+2] == '0);
        w   = a[RAM_AW+1:2];
        en  = (who != 0) && inr;

        chk("if_gnt",  32'(if_gnt),  32'(who == 1));
        chk("dm_gnt",  32'(dm_gnt),  32'(who == 2));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(who == 3));
        chk("ram_en",  32'(ram_en),  32'(en));
        chk("ram_we",  32'(ram_we),  32'((en && we) ? be : 4'h0));
        if (en) chk("ram_addr", 32'(ram_addr), 32'(w));
        if (en && we) chk("ram_wdata", ram_wdata, wd);

        chk("if_rvalid",  32'(if_rvalid),  32'(resp_who == 1));
        chk("dm_rvalid",  32'(dm_rvalid),  32'(resp_who == 2));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(resp_who == 3));
        chk("if_rdata",  if_rdata,  (resp_who == 1) ? resp_data : 32'h0);
        chk("dm_rdata",  dm_rdata,  (resp_who == 2) ? resp_data : 32'h0);
        chk("dbg_rdata", dbg_rdata, (resp_who == 3) ? resp_data : 32'h0);
        chk("oob_err", 32'(oob_err), 32'(oob_pend));
        chk("if_stall_cnt", if_stall_cnt, stall);

        if (who != 0 && !we) begin
            resp_who  = who;
            resp_data = inr ? ref_mem[w] : 32'h0;
        end else begin
            resp_who  = 0;
        end
        if (who != 0 && we && inr)
            ref_mem[w] = (ref_mem[w] & ~be_mask(be)) | (wd & be_mask(be));
        oob_pend = (who != 0) && !inr;
        if (if_req && who != 1) stall = stall + 32'd1;
        if (!if_req || who == 1)                   starve = 0;
        else if (who != 3 && starve < STARVE_MAX)  starve++;
        last_who = who;
    endtask

    task automatic cyc();
        #2;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; dm_req = 1'b0; dbg_req = 1'b0;
        dm_we = 1'b0; dbg_we = 1'b0; dm_be = 4'h0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle();
        for (int i = 0; i < n; i++) begin
            #2;
            chk("rst_gnt",    32'({if_gnt, dm_gnt, dbg_gnt}), 32'h0);
            chk("rst_rvalid", 32'({if_rvalid, dm_rvalid, dbg_rvalid}), 32'h0);
            chk("rst_rdata",  if_rdata | dm_rdata | dbg_rdata, 32'h0);
            chk("rst_ram",    32'({ram_en, ram_we}), 32'h0);
            if (i > 0) begin
                chk("rst_stall", if_stall_cnt, 32'h0);
                chk("rst_oob",   32'(oob_err), 32'h0);
            end
            adv();
        end
        rst = 1'b0;
        starve = 0; stall = '0; resp_who = 0; resp_data = '0; oob_pend = 1'b0; last_who = 0;
    endtask

    task automatic dbg_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        idle();
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        cyc();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(9) == 0) begin
            a = $urandom;
            a[31:16] = 16'($urandom_range(1, 65535));
        end else begin
            a = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
        end
        return a;
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        if_addr = '0; dm_addr = '0; dbg_addr = '0; dm_wdata = '0; dbg_wdata = '0;
        @(posedge clk); #1;
        do_reset(3);

        // Preload the working region through the debug port.
        for (int i = 0; i < 64; i++) begin
            dbg_op(1'b1, 32'(i * 4), $urandom);
            adv();
        end

        // Fetch read hitting a freshly written word.
        dbg_op(1'b1, 32'h40, 32'hDEADBEEF); adv();
        idle(); cyc(); adv();
        idle(); if_req = 1'b1; if_addr = 32'h40; cyc();
        chk("t1_if_gnt", 32'(if_gnt), 32'h1);
        chk("t1_ram_addr", 32'(ram_addr), 32'h10);
        adv();
        idle(); cyc();
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        adv();

        // Fetch starvation bound against continuous data reads.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            idle(); if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_addr = 32'h80;
            cyc();
            chk("t2_dm_gnt", 32'(dm_gnt), 32'(i != 4));
            chk("t2_if_gnt", 32'(if_gnt), 32'(i == 4));
            if (i == 5) chk("t2_stall", if_stall_cnt, 32'd4);
            adv();
        end

        // Debug cycle in the middle of a starvation run does not count.
        idle(); cyc(); adv();
        for (int i = 0; i < 6; i++) begin
            idle(); if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_addr = 32'h8;
            dbg_req = (i == 2); dbg_addr = 32'hC;
            cyc();
            chk("t3_dbg_gnt", 32'(dbg_gnt), 32'(i == 2));
            chk("t3_if_gnt",  32'(if_gnt),  32'(i == 5));
            chk("t3_dm_gnt",  32'(dm_gnt),  32'(i != 2 && i != 5));
            adv();
        end

        // Partial byte write followed by a debug read-back.
        dbg_op(1'b1, 32'h104, 32'h11223344); adv();
        idle(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0010; dm_addr = 32'h104; dm_wdata = 32'h0000AB00;
        cyc();
        chk("t4_ram_we", 32'(ram_we), 32'h2);
        adv();
        dbg_op(1'b0, 32'h104, 32'h0); adv();
        idle(); cyc();
        chk("t4_dbg_rdata", dbg_rdata, 32'h1122AB44);
        adv();

        // Out-of-range data read.
        idle(); dm_req = 1'b1; dm_addr = 32'h0001_0000; cyc();
        chk("t5_ram_en", 32'(ram_en), 32'h0);
        adv();
        idle(); cyc();
        chk("t5_dm_rvalid", 32'(dm_rvalid), 32'h1);
        chk("t5_dm_rdata", dm_rdata, 32'h0);
        chk("t5_oob", 32'(oob_err), 32'h1);
        adv();
        idle(); cyc();
        chk("t5_oob_clr", 32'(oob_err), 32'h0);
        adv();

        // Reset right after a fetch grant suppresses the response.
        idle(); if_req = 1'b1; if_addr = 32'h40; cyc(); adv();
        do_reset(2);
        idle(); cyc();
        chk("t6_stall", if_stall_cnt, 32'h0);
        adv();

        // Randomized traffic obeying the hold-while-pending rule.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) do_reset(2);
            if (!(if_req && last_who != 1) || $urandom_range(7) == 0) begin
                if_req  = ($urandom_range(9) < 6);
                if_addr = rnd_addr();
            end
            if (!(dm_req && last_who != 2) || $urandom_range(7) == 0) begin
                dm_req   = ($urandom_range(9) < 5);
                dm_we    = 1'($urandom_range(1));
                dm_be    = 4'($urandom);
                dm_addr  = rnd_addr();
                dm_wdata = $urandom;
            end
            if (!(dbg_req && last_who != 3) || $urandom_range(7) == 0) begin
                dbg_req   = ($urandom_range(9) < 2);
                dbg_we    = ($urandom_range(2) == 0);
                dbg_addr  = rnd_addr();
                dbg_wdata = $urandom;
            end
            cyc();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
